mem_arbiter: RTL
================

# mem_arbiter

Request arbiter directly upstream of the memory manager FSM. It accepts word-aligned instruction-fetch requests from the fetch stage and load/store requests from the datapath, and serialises them onto the manager's single request port (memRead/memWrite, data_en/instr_en, address_in, data_in_CPU). It tracks the manager's state to detect completion, then returns registered read data and a one-cycle ack to the requester. Data accesses have priority over fetches.

## Interface
- No parameters; all address/data paths are fixed at 32 bits.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level; held until if_ack
- if_addr  in  32  fetch address (PC); stable while if_req
- if_ack  out  1  one-cycle completion pulse
- if_instr  out  32  fetched word; valid with if_ack, held until next fetch ack
- if_err  out  1  with if_ack: misaligned fetch, no access made
- dm_read / dm_write  in  1  load / store request, level; held until dm_ack
- dm_addr  in  32  load/store address
- dm_wdata  in  32  store data
- dm_ack  out  1  one-cycle completion pulse
- dm_rdata  out  32  load data; valid with dm_ack, held until next load ack
- dm_err  out  1  with dm_ack: misaligned address, or dm_read and dm_write both high
- mm_state  in  state_t  memory manager current state
- mm_data_cpu / mm_data_instr  in  32  manager data_out_CPU / data_out_INSTR
- address_in, data_in_CPU  out  32  to manager
- memRead, memWrite, data_en, instr_en  out  1  to manager
- busy  out  1  high whenever the arbiter is not in A_IDLE

## Operation
- FSM states: A_IDLE, A_ISSUE, A_BUSY, A_DONE.
- A_IDLE: a data request (dm_read|dm_write) wins over if_req.
  - Error case: misaligned address (addr[1:0]≠0) or dm_read&dm_write. Latch an error flag, issue nothing, go to A_DONE.
  - Otherwise: latch address, kind (fetch/load/store) and wdata, then go to A_ISSUE.
- A_ISSUE: drive address_in from the latched address.
  - Store: data_in_CPU = latched wdata; load/fetch: data_in_CPU = 0.
  - Assert exactly one of memRead/memWrite. Assert data_en for load/store, instr_en for fetch.
  - Go to A_BUSY once mm_state==IDLE. Otherwise stay, e.g. while the manager is in INIT after reset.
- A_BUSY: hold address_in, data_in_CPU, data_en and instr_en; deassert memRead/memWrite.
  - mm_state==Read: capture mm_data_cpu into dm_rdata (load) or mm_data_instr into if_instr (fetch), then go to A_DONE.
  - mm_state==Write: go to A_DONE.
  - Read_Request, Write_Request and Wait: stay in A_BUSY.
- A_DONE: pulse if_ack or dm_ack for the latched kind, with err = the latched flag. Drive all manager outputs to 0. Go to A_IDLE.
- Requesters drop or replace their request on the cycle after the ack. The arbiter does not re-sample requests in A_DONE.
- A fetch that arrives during a data transaction waits in A_IDLE arbitration. No request is ever dropped.

## Timing
- Reset: state A_IDLE. All outputs 0, including if_instr, dm_rdata and both acks.
- Reset mid-transaction: abandon the transaction with no ack; the manager is reset by the same rst.
- Nominal path (bus not full): request cycle 0 → A_ISSUE cycle 1 → manager Read_Request/Write_Request cycle 2 → Read/Write cycle 3 → ack cycle 4.
- Each manager Wait cycle adds one cycle.
- Error path: request cycle 0 → ack + err cycle 1.
- Back-to-back: a new request seen in A_IDLE on cycle 5 issues on cycle 6. Sustained throughput is one transaction per 5 cycles.
- If data and fetch are requested simultaneously: data ack at cycle 4, fetch ack at cycle 9.

## Structure
- A shared package mem_pkg holds:
  - the manager's state_t, moved out of the manager and imported by both blocks;
  - the arbiter's arb_state_t;
  - the request-kind enum (K_FETCH, K_LOAD, K_STORE).
- Single module with no sub-module: a latch stage plus a 4-state FSM.

## Test plan
- Fetch at 0x0000_0010, manager stub returns 0x0013_0093 in Read with no bus_full → if_ack in cycle 4, if_instr=0x0013_0093, instr_en high cycles 1-3.
- Store 0xDEAD_BEEF to 0x100 with 3 bus_full cycles → memWrite only in A_ISSUE, data_in_CPU=0xDEAD_BEEF held, dm_ack in cycle 7.
- if_req and dm_read asserted in the same cycle → load acked at cycle 4, fetch acked at cycle 9, never both in one cycle.
- dm_read to 0x102 → dm_ack+dm_err at cycle 1, memRead never asserted, dm_rdata unchanged. Repeat with dm_read&dm_write both high → same response.
- rst asserted in A_BUSY → next cycle all outputs 0, no ack. A following fetch completes normally after the manager passes INIT, with A_ISSUE held until mm_state==IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Types shared by the memory manager and the request arbiter in front of it.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Memory manager states, observed by the arbiter to detect completion.
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        Read_Request,
        Write_Request,
        Wait,
        Read,
        Write
    } state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_ISSUE,
        A_BUSY,
        A_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        K_FETCH,
        K_LOAD,
        K_STORE
    } req_kind_t;

    // One accepted request, as held for the lifetime of a transaction.
    typedef struct packed {
        req_kind_t         kind;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and load/store requests onto the memory
// manager's single request port; data accesses win over fetches.
module mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_err,

    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,

    input  state_t            mm_state,
    input  logic [DATA_W-1:0] mm_data_cpu,
    input  logic [DATA_W-1:0] mm_data_instr,
    output logic [ADDR_W-1:0] address_in,
    output logic [DATA_W-1:0] data_in_CPU,
    output logic              memRead,
    output logic              memWrite,
    output logic              data_en,
    output logic              instr_en,

    output logic              busy
);

    arb_state_t        state_q, state_d;
    req_t              req_q, req_d;
    req_t              cand;
    logic              req_any;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    assign req_any = dm_read | dm_write | if_req;

    // Candidate request for this cycle; a data access always beats a fetch.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no
        // path leaves a combinational output unassigned and no latch is inferred.
        cand.kind  = K_FETCH;
        cand.err   = is_misaligned(if_addr);
        cand.addr  = if_addr;
        cand.wdata = '0;
        if (dm_read || dm_write) begin
            cand.kind  = (dm_write && !dm_read) ? K_STORE : K_LOAD;
            cand.err   = is_misaligned(dm_addr) || (dm_read && dm_write);
            cand.addr  = dm_addr;
            cand.wdata = dm_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        if_instr_d = if_instr_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            A_IDLE: begin
                if (req_any) begin
                    req_d   = cand;
                    state_d = cand.err ? A_DONE : A_ISSUE;
                end
            end
            A_ISSUE: begin
                // The manager only accepts a request from IDLE (not INIT).
                if (mm_state == IDLE) begin
                    state_d = A_BUSY;
                end
            end
            A_BUSY: begin
                case (mm_state)
                    Read: begin
                        if (req_q.kind == K_FETCH) begin
                            if_instr_d = mm_data_instr;
                        end else begin
                            dm_rdata_d = mm_data_cpu;
                        end
                        state_d = A_DONE;
                    end
                    Write:   state_d = A_DONE;
                    default: state_d = A_BUSY;
                endcase
            end
            A_DONE:  state_d = A_IDLE;
            default: state_d = A_IDLE;
        endcase
    end

    // Manager-side and requester-side outputs decode from the held request.
    always_comb begin
        address_in  = '0;
        data_in_CPU = '0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        data_en     = 1'b0;
        instr_en    = 1'b0;
        if_ack      = 1'b0;
        if_err      = 1'b0;
        dm_ack      = 1'b0;
        dm_err      = 1'b0;

        case (state_q)
            A_ISSUE, A_BUSY: begin
                address_in  = req_q.addr;
                data_in_CPU = (req_q.kind == K_STORE) ? req_q.wdata : '0;
                data_en     = (req_q.kind != K_FETCH);
                instr_en    = (req_q.kind == K_FETCH);
                if (state_q == A_ISSUE) begin
                    memRead  = (req_q.kind != K_STORE);
                    memWrite = (req_q.kind == K_STORE);
                end
            end
            A_DONE: begin
                if (req_q.kind == K_FETCH) begin
                    if_ack = 1'b1;
                    if_err = req_q.err;
                end else begin
                    dm_ack = 1'b1;
                    dm_err = req_q.err;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state_q != A_IDLE);
    assign if_instr = if_instr_q;
    assign dm_rdata = dm_rdata_q;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= A_IDLE;
            // NOTE: the returned-data registers are reset too, because their
            // value is architecturally visible (zero) straight after reset.
            req_q      <= '{kind: K_FETCH, err: 1'b0, addr: '0, wdata: '0};
            if_instr_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            if_instr_q <= if_instr_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule
